// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, with unsigned
// or two's-complement operands and a registered divide-by-zero result.
module seq_div #(
   parameter int WIDTH  = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             last;
   logic             y_zero;

   logic [WIDTH:0]   prem;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic             q_neg;
   logic             r_neg;

   logic             x_neg, y_neg;
   logic [WIDTH-1:0] x_mag, y_mag;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             qbit;
   logic [WIDTH:0]   prem_nxt;
   logic [WIDTH-1:0] sreg_nxt;
   logic [WIDTH-1:0] r_mag;

   assign x_neg  = SIGNED && x[WIDTH-1];
   assign y_neg  = SIGNED && y[WIDTH-1];
   assign x_mag  = x_neg ? -x : x;
   assign y_mag  = y_neg ? -y : y;
   assign y_zero = (y == '0);
   assign last   = (cnt == LAST_ITER);

   // Partial remainder always stays below the divisor, so one extra bit above
   // the shifted value is enough to read the trial-subtract sign.
   assign shifted  = {prem, sreg[WIDTH-1]};
   assign diff     = shifted - {2'b00, dvs};
   assign qbit     = ~diff[WIDTH+1];
   assign prem_nxt = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
   assign sreg_nxt = {sreg[WIDTH-2:0], qbit};
   assign r_mag    = prem_nxt[WIDTH-1:0];

   assign busy = (state == CALC);
   assign done = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: defaults come first so every path assigns every output and no latch
   // is inferred.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (start) begin
               accept    = 1'b1;
               state_nxt = y_zero ? DONE : CALC;
            end
         end
         CALC:    if (last) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prem        <= '0;
         sreg        <= '0;
         dvs         <= '0;
         cnt         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         prem  <= '0;
         sreg  <= x_mag;
         dvs   <= y_mag;
         cnt   <= '0;
         q_neg <= x_neg ^ y_neg;
         r_neg <= x_neg;
         if (y_zero) begin
            quotient    <= '1;
            remainder   <= x;
            div_by_zero <= 1'b1;
         end
      end else if (state == CALC) begin
         prem <= prem_nxt;
         sreg <= sreg_nxt;
         cnt  <= cnt + CW'(1);
         if (last) begin
            quotient    <= q_neg ? -sreg_nxt : sreg_nxt;
            remainder   <= r_neg ? -r_mag : r_mag;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: unsigned/signed 4-bit and unsigned 8-bit instances,
// covering latency, divide-by-zero, signed corners, back-to-back, ignore and reset.
module tb_seq_div;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 4-bit unsigned
   logic       a_start;
   logic [3:0] a_x, a_y, a_q, a_r;
   logic       a_busy, a_done, a_dz;
   // 4-bit signed
   logic       b_start;
   logic [3:0] b_x, b_y, b_q, b_r;
   logic       b_busy, b_done, b_dz;
   // 8-bit unsigned
   logic       c_start;
   logic [7:0] c_x, c_y, c_q, c_r;
   logic       c_busy, c_done, c_dz;

   seq_div #(.WIDTH(4), .SIGNED(1'b0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .x(a_x), .y(a_y),
      .busy(a_busy), .done(a_done), .quotient(a_q), .remainder(a_r), .div_by_zero(a_dz));
   seq_div #(.WIDTH(4), .SIGNED(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .x(b_x), .y(b_y),
      .busy(b_busy), .done(b_done), .quotient(b_q), .remainder(b_r), .div_by_zero(b_dz));
   seq_div #(.WIDTH(8), .SIGNED(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(c_start), .x(c_x), .y(c_y),
      .busy(c_busy), .done(c_done), .quotient(c_q), .remainder(c_r), .div_by_zero(c_dz));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input logic [3:0] xv, input logic [3:0] yv);
      a_x = xv; a_y = yv; a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   task automatic start_b(input logic [3:0] xv, input logic [3:0] yv);
      b_x = xv; b_y = yv; b_start = 1'b1;
      tick();
      b_start = 1'b0;
   endtask

   task automatic check_a(input string tag, input logic busy_e, input logic done_e,
                          input logic [3:0] q_e, input logic [3:0] r_e, input logic dz_e);
      check({tag, ".busy"}, 32'(a_busy), 32'(busy_e));
      check({tag, ".done"}, 32'(a_done), 32'(done_e));
      check({tag, ".q"},    32'(a_q),    32'(q_e));
      check({tag, ".r"},    32'(a_r),    32'(r_e));
      check({tag, ".dz"},   32'(a_dz),   32'(dz_e));
   endtask

   task automatic check_b(input string tag, input logic [3:0] q_e, input logic [3:0] r_e,
                          input logic dz_e);
      check({tag, ".done"}, 32'(b_done), 32'd1);
      check({tag, ".q"},    32'(b_q),    32'(q_e));
      check({tag, ".r"},    32'(b_r),    32'(r_e));
      check({tag, ".dz"},   32'(b_dz),   32'(dz_e));
   endtask

   initial begin
      rst_n = 1'b0;
      a_start = 1'b0; a_x = '0; a_y = '0;
      b_start = 1'b0; b_x = '0; b_y = '0;
      c_start = 1'b0; c_x = '0; c_y = '0;
      #3;
      check_a("reset", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // 13/3: busy for 4 cycles, done at E4
      start_a(4'd13, 4'd3);
      check("u13_3.busy_e0", 32'(a_busy), 32'd1);
      check("u13_3.done_e0", 32'(a_done), 32'd0);
      repeat (3) tick();
      check("u13_3.busy_e3", 32'(a_busy), 32'd1);
      check("u13_3.done_e3", 32'(a_done), 32'd0);
      tick();
      check_a("u13_3.e4", 1'b0, 1'b1, 4'd4, 4'd1, 1'b0);
      tick();
      check_a("u13_3.hold", 1'b0, 1'b0, 4'd4, 4'd1, 1'b0);

      // 9/0: one-cycle done, no busy
      start_a(4'd9, 4'd0);
      check_a("u9_0.e0", 1'b0, 1'b1, 4'hF, 4'd9, 1'b1);
      tick();
      check_a("u9_0.e1", 1'b0, 1'b0, 4'hF, 4'd9, 1'b1);

      // start during CALC ignored
      start_a(4'd13, 4'd3);
      tick();
      a_x = 4'd15; a_y = 4'd1; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("ign.busy_e2", 32'(a_busy), 32'd1);
      tick();
      check("ign.done_e3", 32'(a_done), 32'd0);
      tick();
      check_a("ign.e4", 1'b0, 1'b1, 4'd4, 4'd1, 1'b0);
      tick();
      check("ign.busy_e5", 32'(a_busy), 32'd0);
      check("ign.done_e5", 32'(a_done), 32'd0);
      tick();
      check("ign.done_e6", 32'(a_done), 32'd0);

      // asynchronous reset in the middle of the second cycle
      start_a(4'd13, 4'd3);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check_a("rst.async", 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rst.no_done", 32'(a_done), 32'd0);
      end
      start_a(4'd6, 4'd4);
      repeat (3) tick();
      check("u6_4.done_e3", 32'(a_done), 32'd0);
      tick();
      check_a("u6_4.e4", 1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
      tick();

      // signed: -7/2, -8/-1, 7/-2, -3/0
      start_b(4'b1001, 4'd2);
      repeat (3) tick();
      check("s_m7_2.done_e3", 32'(b_done), 32'd0);
      tick();
      check_b("s_m7_2", 4'b1101, 4'b1111, 1'b0);
      tick();
      start_b(4'b1000, 4'b1111);
      repeat (4) tick();
      check_b("s_m8_m1", 4'b1000, 4'b0000, 1'b0);
      tick();
      start_b(4'd7, 4'b1110);
      repeat (4) tick();
      check_b("s_7_m2", 4'b1101, 4'b0001, 1'b0);
      tick();
      start_b(4'b1101, 4'd0);
      check_b("s_m3_0", 4'hF, 4'b1101, 1'b1);
      check("s_m3_0.busy", 32'(b_busy), 32'd0);
      tick();

      // 8-bit: 255/16, then back-to-back 100/7 accepted in the DONE cycle
      c_x = 8'd255; c_y = 8'd16; c_start = 1'b1;
      tick();
      c_start = 1'b0;
      repeat (7) tick();
      check("w8_255.busy_e7", 32'(c_busy), 32'd1);
      check("w8_255.done_e7", 32'(c_done), 32'd0);
      tick();
      check("w8_255.done_e8", 32'(c_done), 32'd1);
      check("w8_255.q",       32'(c_q),    32'd15);
      check("w8_255.r",       32'(c_r),    32'd15);
      check("w8_255.dz",      32'(c_dz),   32'd0);
      c_x = 8'd100; c_y = 8'd7; c_start = 1'b1;
      tick();
      c_start = 1'b0;
      check("w8_b2b.done_e9", 32'(c_done), 32'd0);
      check("w8_b2b.busy_e9", 32'(c_busy), 32'd1);
      check("w8_b2b.q_hold",  32'(c_q),    32'd15);
      repeat (7) tick();
      check("w8_b2b.done_e16", 32'(c_done), 32'd0);
      tick();
      check("w8_b2b.done_e17", 32'(c_done), 32'd1);
      check("w8_b2b.q",        32'(c_q),    32'd14);
      check("w8_b2b.r",        32'(c_r),    32'd2);
      tick();
      check("w8_b2b.done_e18", 32'(c_done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_div.md
# seq_div

Parametrised sequential radix-2 restoring divider for the calculator datapath. It is the multi-cycle successor to the 4-bit combinational divide unit. It accepts a dividend and divisor on a start pulse and iterates one quotient bit per clock. It returns the quotient, the remainder and a divide-by-zero flag with a one-cycle done pulse, in unsigned or two's-complement mode.

## Interface

Parameters:
- WIDTH, 4: operand, quotient and remainder width in bits; legal range 2..32.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  request; sampled only on edges where the block is in IDLE or DONE.
- x  in  WIDTH  dividend; captured on the accepting edge.
- y  in  WIDTH  divisor; captured on the accepting edge.
- busy  out  1  high while in CALC.
- done  out  1  high for exactly one cycle (DONE state) per accepted request.
- quotient  out  WIDTH  registered result; holds until the next completion.
- remainder  out  WIDTH  registered result; holds until the next completion.
- div_by_zero  out  1  registered; valid with done; holds until the next completion.

## Operation

States:
- IDLE: waits for start.
- CALC: WIDTH iterations, one per edge.
- DONE: one cycle; then goes to IDLE, or directly into a new request if start is high.

Accept and capture:
- Accept occurs on an edge in IDLE or DONE with start=1.
- Capture magnitudes |x| and |y|: raw values when SIGNED=0; negate-if-negative when SIGNED=1.
- Capture sign flags: q_neg = x[MSB]^y[MSB]; r_neg = x[MSB]. Both flags are forced to 0 when SIGNED=0.
- Clear the WIDTH+1-bit partial remainder.
- Load the shift register with |x| and clear the iteration counter.

Iteration (per CALC edge):
- Shift the partial remainder left, bringing in the dividend MSB.
- Trial-subtract |y|.
- If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
- Counter width is clog2(WIDTH+1).

Completion (edge ending the WIDTH-th iteration):
- Go to DONE.
- quotient = q_neg ? -q : q, truncated to WIDTH bits.
- remainder = r_neg ? -r : r, truncated to WIDTH bits.
- div_by_zero = 0.

Divide by zero (y == 0 on the accepting edge):
- Skip CALC and go straight to DONE on the accepting edge.
- quotient = all ones, remainder = x unchanged, div_by_zero = 1.

Signed boundary cases:
- Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Most-negative / -1 wraps: quotient = most-negative value, remainder = 0, no flag.

Ignored and abort conditions:
- start while in CALC is ignored; the operation in flight continues and x/y are not re-captured.
- Reset asserted at any time aborts the operation. No done pulse is produced for the aborted request.

## Timing

- Reset values: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, internal registers 0.
- Accepting edge E0 with y≠0:
  - busy is high from E0 until E_WIDTH.
  - done is high from E_WIDTH to E_WIDTH+1.
  - Results are updated at E_WIDTH.
  - Latency start→done is WIDTH cycles.
- Accepting edge E0 with y=0: done is high from E0 to E1; latency is 1 cycle; busy stays 0.
- Back-to-back: start=1 during the DONE cycle is accepted at E_WIDTH+1. done then drops and busy rises on the same edge. Throughput is one result per WIDTH+1 cycles.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan

- WIDTH=4, SIGNED=0, x=13, y=3, start pulse at E0 -> busy for 4 cycles; done at E4 with quotient=4, remainder=1, div_by_zero=0.
- WIDTH=4, SIGNED=0, x=9, y=0 -> done in the cycle after E0 with quotient=4'hF, remainder=9, div_by_zero=1; busy never high.
- WIDTH=4, SIGNED=1:
  - x=-7, y=2 -> quotient=4'b1101 (-3), remainder=4'b1111 (-1).
  - x=-8, y=-1 -> quotient=4'b1000, remainder=0, div_by_zero=0.
- WIDTH=8, SIGNED=0: 255/16 -> quotient=15, remainder=15 after 8 cycles. Then start held high in the DONE cycle with 100/7 -> accepted immediately; next done 9 cycles later with quotient=14, remainder=2.
- WIDTH=4: start 13/3, re-pulse start with 15/1 two cycles later -> second start is ignored; the single done carries quotient=4, remainder=1.
- Reset: start 13/3, drop rst_n asynchronously mid-cycle 2 -> all outputs 0 immediately, no done after release. A fresh start 6/4 then completes with quotient=1, remainder=2.
